pdm_sequencer: RTL and testbench
================================

Name: pdm_sequencer

Overview:
- Pattern playback controller that drives the existing 5-bit PDM core's level/write-enable interface.
- Holds a small loadable table of PDM levels and replays it at a programmable per-sample hold period.
- Issues one write pulse per new level, so the PDM core needs no external per-sample sequencing.
- Sits between the user_module pin map and the PDM core: its level output drives the core's level input; its write-enable output drives the core's write-enable input.

Parameters:
- WIDTH, 5: PDM level width; matches the PDM core input.
- DEPTH, 8: pattern table entries; power of two, at least 2.
- HOLD_W, 8: width of the hold-period config.

Ports:
- clk  input  1  single clock for all state.
- reset  input  1  asynchronous, active-high reset.
- cfg_hold  input  HOLD_W  sample period minus 1, in clk cycles.
- load_valid  input  1  write load_data into the next free table entry.
- load_data  input  WIDTH  level to load.
- load_ready  output  1  table accepts a load this cycle.
- clear  input  1  empty the table (IDLE only).
- start  input  1  begin playback.
- stop  input  1  end playback.
- pdm_level  output  WIDTH  level presented to the PDM core.
- pdm_write_en  output  1  one-cycle strobe; PDM core latches pdm_level.
- busy  output  1  high while playing.
- sample_idx  output  clog2(DEPTH)  table index currently presented.

Behaviour:
- States: IDLE, PLAY.
- Internal registers: len (0..DEPTH), rd_ptr, hold_cnt.
- All outputs are registered; busy = (state==PLAY).

Reset (asynchronous, takes effect immediately, including mid-playback):
- state=IDLE; len=0; rd_ptr=0; hold_cnt=0.
- pdm_level=0; pdm_write_en=0; sample_idx=0.
- Table contents are not reset; len=0 makes them unreachable.

load_ready:
- load_ready = (state==IDLE) && (len<DEPTH).

IDLE:
- load_valid && load_ready: table[len] <= load_data; len++.
- load_valid while full, or while in PLAY: ignored.
- clear: len <= 0. clear together with load_valid: clear wins and the load is dropped.
- start with len==0 after any same-cycle load: ignored.
- start with len>0: at the edge ending cycle N, state<=PLAY, rd_ptr<=0, pdm_level<=table[0], pdm_write_en<=1, hold_cnt<=cfg_hold. The first strobe is therefore visible in cycle N+1.
- start and load_valid in the same cycle: the load is stored first, and start uses the incremented len (new entry included).

PLAY:
- pdm_write_en defaults to 0.
- hold_cnt!=0: hold_cnt decrements by 1.
- hold_cnt==0: rd_ptr advances (len-1 wraps to 0), pdm_level<=table[next], pdm_write_en<=1, hold_cnt<=cfg_hold (sampled at reload).
- Resulting sample period is cfg_hold+1 cycles. cfg_hold=0 strobes every cycle.
- len==1: the same level is re-strobed every period.
- stop: next state IDLE, pdm_level<=0, pdm_write_en<=1 (one cycle, forces the core to silence), rd_ptr<=0. len and table contents are kept.
- start and stop in the same cycle: stop wins in both states.
- start while already in PLAY: ignored.
- clear while in PLAY: ignored.

Other rules:
- sample_idx mirrors rd_ptr.
- cfg_hold changes mid-sample take effect at the next reload only.

Optional Feature:
- Macro: PDM_SEQ_PINGPONG_EN.
- Defined: rd_ptr bounces between 0 and len-1 without repeating endpoints, e.g. len=3 gives 0,1,2,1,0,1,...; len==1 stays at 0. A one-bit direction register is added, reset to "up", and set to "up" on start.
- Undefined: playback wraps 0..len-1,0,...; no direction register is instantiated.

Decomposition:
- Package pdm_seq_pkg: state encoding (IDLE, PLAY), default WIDTH/DEPTH constants.
- Sub-module pdm_seq_mem: DEPTH x WIDTH register file, one synchronous write port, one asynchronous read port, no reset.
- All control logic stays in pdm_sequencer.

Test Plan:
- Load 3,10,20,31; cfg_hold=3; start in cycle N -> strobes in N+1, N+5, N+9, N+13, N+17 with levels 3,10,20,31,3; busy=1 from N+1.
- Load 9 entries with DEPTH=8 -> load_ready low after the 8th load; 9th dropped; playback cycles 8 levels; cfg_hold=0 gives a strobe every cycle.
- start with len==0 -> stays IDLE, busy=0, no strobe. start+load_valid(7) together from empty -> PLAY, first level 7.
- stop asserted two cycles after a strobe -> next cycle pdm_write_en=1, pdm_level=0, busy=0. Restart -> first level is table[0]. start+stop together -> remains IDLE.
- reset asserted mid-playback between clock edges -> pdm_level=0, pdm_write_en=0, busy=0 immediately; after release, start is ignored (len=0).
- PDM_SEQ_PINGPONG_EN, load 5,6,7, cfg_hold=0 -> levels 5,6,7,6,5,6,7. Without the macro -> 5,6,7,5,6,7.

Source files
------------

// File: rtl/pdm_seq_pkg.sv
// Shared types and default sizes for the PDM pattern sequencer.
package pdm_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/pdm_seq_mem.sv
// Pattern table: DEPTH x WIDTH register file, one synchronous write port,
// one asynchronous read port, no reset (contents gated by the length count).
module pdm_seq_mem #(
   parameter int WIDTH = pdm_seq_pkg::DEFAULT_WIDTH,
   parameter int DEPTH = pdm_seq_pkg::DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/pdm_sequencer.sv
// Loadable level table replayed into the PDM core with one write strobe per sample.
// Optional macro PDM_SEQ_PINGPONG_EN: bounce playback 0..len-1..0 instead of wrapping.
module pdm_sequencer
   import pdm_seq_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int HOLD_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [HOLD_W-1:0]        cfg_hold,
   input  logic                     load_valid,
   input  logic [WIDTH-1:0]         load_data,
   output logic                     load_ready,
   input  logic                     clear,
   input  logic                     start,
   input  logic                     stop,
   output logic [WIDTH-1:0]         pdm_level,
   output logic                     pdm_write_en,
   output logic                     busy,
   output logic [$clog2(DEPTH)-1:0] sample_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_e            state_q, state_d;
   logic [AW:0]       len_q, len_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [WIDTH-1:0]  pdm_level_q, pdm_level_d;
   logic              pdm_write_en_q, pdm_write_en_d;

   logic              mem_we;
   logic [AW-1:0]     mem_raddr;
   logic [WIDTH-1:0]  mem_rdata;
   logic [AW-1:0]     next_ptr;
   logic [AW:0]       len_m1;
   logic              at_last;
   logic              load_acc;

   assign len_m1  = len_q - 1'b1;
   assign at_last = ({1'b0, rd_ptr_q} == len_m1);

`ifdef PDM_SEQ_PINGPONG_EN
   logic dir_up_q, dir_up_d, dir_next;

   always_comb begin
      next_ptr = '0;
      dir_next = dir_up_q;
      if (len_q > (AW+1)'(1)) begin
         if (dir_up_q) begin
            if (at_last) begin
               next_ptr = rd_ptr_q - 1'b1;
               dir_next = 1'b0;
            end else begin
               next_ptr = rd_ptr_q + 1'b1;
            end
         end else if (rd_ptr_q == '0) begin
            next_ptr = AW'(1);
            dir_next = 1'b1;
         end else begin
            next_ptr = rd_ptr_q - 1'b1;
         end
      end
   end
`else
   always_comb begin
      next_ptr = at_last ? '0 : rd_ptr_q + 1'b1;
   end
`endif

   assign load_acc = load_valid && (state_q == IDLE) && (len_q < DEPTH_L) && !clear;

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      rd_ptr_d       = rd_ptr_q;
      hold_cnt_d     = hold_cnt_q;
      pdm_level_d    = pdm_level_q;
      pdm_write_en_d = 1'b0;
      mem_we         = 1'b0;
      mem_raddr      = next_ptr;
`ifdef PDM_SEQ_PINGPONG_EN
      dir_up_d       = dir_up_q;
`endif
      unique case (state_q)
         IDLE: begin
            mem_raddr = '0;
            if (clear) begin
               len_d = '0;
            end else begin
               if (load_acc) begin
                  mem_we = 1'b1;
                  len_d  = len_q + 1'b1;
               end
               // Loading into an empty table: entry 0 is not written yet, so bypass it.
               if (start && !stop && (len_d != '0)) begin
                  state_d        = PLAY;
                  rd_ptr_d       = '0;
                  pdm_level_d    = (len_q == '0) ? load_data : mem_rdata;
                  pdm_write_en_d = 1'b1;
                  hold_cnt_d     = cfg_hold;
`ifdef PDM_SEQ_PINGPONG_EN
                  dir_up_d       = 1'b1;
`endif
               end
            end
         end
         PLAY: begin
            if (stop) begin
               state_d        = IDLE;
               pdm_level_d    = '0;
               pdm_write_en_d = 1'b1;
               rd_ptr_d       = '0;
               hold_cnt_d     = '0;
            end else if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end else begin
               rd_ptr_d       = next_ptr;
               pdm_level_d    = mem_rdata;
               pdm_write_en_d = 1'b1;
               hold_cnt_d     = cfg_hold;
`ifdef PDM_SEQ_PINGPONG_EN
               dir_up_d       = dir_next;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         len_q          <= '0;
         rd_ptr_q       <= '0;
         hold_cnt_q     <= '0;
         pdm_level_q    <= '0;
         pdm_write_en_q <= 1'b0;
`ifdef PDM_SEQ_PINGPONG_EN
         dir_up_q       <= 1'b1;
`endif
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         rd_ptr_q       <= rd_ptr_d;
         hold_cnt_q     <= hold_cnt_d;
         pdm_level_q    <= pdm_level_d;
         pdm_write_en_q <= pdm_write_en_d;
`ifdef PDM_SEQ_PINGPONG_EN
         dir_up_q       <= dir_up_d;
`endif
      end
   end

   pdm_seq_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (len_q[AW-1:0]),
      .wdata (load_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign load_ready   = (state_q == IDLE) && (len_q < DEPTH_L);
   assign pdm_level    = pdm_level_q;
   assign pdm_write_en = pdm_write_en_q;
   assign busy         = (state_q == PLAY);
   assign sample_idx   = rd_ptr_q;

endmodule

// File: tb/tb_pdm_sequencer.sv
// Directed + randomized bench for pdm_sequencer against a queue-based playback model.
// Honours PDM_SEQ_PINGPONG_EN for the expected playback order.
module tb_pdm_sequencer;

   localparam int WIDTH  = 5;
   localparam int DEPTH  = 8;
   localparam int HOLD_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [HOLD_W-1:0] cfg_hold;
   logic              load_valid;
   logic [WIDTH-1:0]  load_data;
   logic              load_ready;
   logic              clear;
   logic              start;
   logic              stop;
   logic [WIDTH-1:0]  pdm_level;
   logic              pdm_write_en;
   logic              busy;
   logic [2:0]        sample_idx;

   int total = 0;
   int bad   = 0;
   int mtbl[$];

   pdm_sequencer #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .HOLD_W (HOLD_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_hold     (cfg_hold),
      .load_valid   (load_valid),
      .load_data    (load_data),
      .load_ready   (load_ready),
      .clear        (clear),
      .start        (start),
      .stop         (stop),
      .pdm_level    (pdm_level),
      .pdm_write_en (pdm_write_en),
      .busy         (busy),
      .sample_idx   (sample_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Table index of the k-th sample after start, for a table of n entries.
   function automatic int exp_idx(input int k, input int n);
`ifdef PDM_SEQ_PINGPONG_EN
      int per, p;
      if (n == 1) return 0;
      per = 2 * (n - 1);
      p   = k % per;
      return (p < n) ? p : per - p;
`else
      return k % n;
`endif
   endfunction

   task automatic do_load(input int v);
      int m;
      m = v & 31;
      load_valid = 1'b1;
      load_data  = WIDTH'(m);
      chk("load_ready_before_load", load_ready, mtbl.size() < DEPTH);
      tick();
      if (mtbl.size() < DEPTH) mtbl.push_back(m);
      load_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mtbl.delete();
      chk("load_ready_after_clear", load_ready, 1);
   endtask

   task automatic start_play(input int h);
      cfg_hold = HOLD_W'(h);
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Check n cycles of playback starting at the cycle of the first strobe,
   // while throwing ignored load/clear/start requests at the DUT.
   task automatic play_run(input int h, input int n);
      for (int c = 0; c < n; c++) begin
         int ix;
         ix = exp_idx(c / (h + 1), mtbl.size());
         chk("busy_play", busy, 1);
         chk("load_ready_play", load_ready, 0);
         chk("write_en_play", pdm_write_en, (c % (h + 1)) == 0);
         chk("level_play", pdm_level, mtbl[ix]);
         chk("sample_idx_play", sample_idx, ix);
         load_valid = 1'($urandom);
         load_data  = WIDTH'($urandom);
         clear      = 1'($urandom);
         start      = 1'($urandom);
         if (c != n - 1) tick();
      end
      load_valid = 1'b0;
      clear      = 1'b0;
      start      = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_write_en", pdm_write_en, 1);
      chk("stop_level", pdm_level, 0);
      chk("stop_busy", busy, 0);
      chk("stop_idx", sample_idx, 0);
      tick();
      chk("after_stop_write_en", pdm_write_en, 0);
      chk("after_stop_busy", busy, 0);
      chk("after_stop_load_ready", load_ready, mtbl.size() < DEPTH);
   endtask

   initial begin
      int h, n;
      reset      = 1'b1;
      cfg_hold   = '0;
      load_valid = 1'b0;
      load_data  = '0;
      clear      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", pdm_level, 0);
      chk("rst_write_en", pdm_write_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", sample_idx, 0);
      chk("rst_load_ready", load_ready, 1);
      reset = 1'b0;
      tick();

      // Fixed pattern, hold 3: strobes every 4 cycles, stop two cycles after a strobe.
      do_load(3); do_load(10); do_load(20); do_load(31);
      start_play(3);
      play_run(3, 23);
      do_stop();

      // Restart begins again at entry 0.
      h = $urandom_range(0, 3);
      start_play(h);
      play_run(h, 3 * (h + 1));
      do_stop();

      // start and stop together in IDLE.
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_write_en", pdm_write_en, 0);

      // clear beats a same-cycle load; table is then empty.
      clear = 1'b1; load_valid = 1'b1; load_data = 5'd9;
      tick();
      clear = 1'b0; load_valid = 1'b0;
      mtbl.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("empty_start_busy", busy, 0);
      chk("empty_start_write_en", pdm_write_en, 0);
      tick();
      chk("empty_start_busy_later", busy, 0);

      // start with a same-cycle load into the empty table.
      load_valid = 1'b1; load_data = 5'd7; start = 1'b1; cfg_hold = '0;
      tick();
      load_valid = 1'b0; start = 1'b0;
      mtbl.push_back(7);
      play_run(0, 4);
      do_stop();

      // Overfill: ninth load dropped, eight levels replayed every cycle.
      do_clear();
      for (int i = 0; i < 9; i++) do_load(int'($urandom));
      chk("full_load_ready", load_ready, 0);
      start_play(0);
      play_run(0, 12);
      do_stop();

      // 5,6,7 at hold 0: wrap or bounce depending on the build.
      do_clear();
      do_load(5); do_load(6); do_load(7);
      start_play(0);
      play_run(0, 7);
      do_stop();

      // Randomized tables and hold periods, including a single-entry table.
      for (int r = 0; r < 6; r++) begin
         do_clear();
         n = (r == 0) ? 1 : $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) do_load(int'($urandom));
         h = $urandom_range(0, 4);
         start_play(h);
         play_run(h, $urandom_range(1, 40));
         do_stop();
      end

      // Asynchronous reset between clock edges during playback.
      do_clear();
      do_load(12); do_load(25);
      start_play(1);
      play_run(1, 3);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_level", pdm_level, 0);
      chk("async_rst_write_en", pdm_write_en, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_idx", sample_idx, 0);
      #2;
      reset = 1'b0;
      mtbl.delete();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("post_rst_start_busy", busy, 0);
      chk("post_rst_start_write_en", pdm_write_en, 0);
      chk("post_rst_load_ready", load_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
